aes_stream_loader: RTL and testbench

- Byte-serial front-end that sits directly upstream of the AES core and also collects its result.
- Assembles a K-bit key and a 128-bit message from an 8-bit valid/ready input stream, then drives the core's load/enable.
- Waits for the core's done, latches the 128-bit result, and streams it out as 16 bytes on a valid/ready output.
- A watchdog aborts the operation if the core never signals done.

---
 rtl/aes_stream_loader.sv | 198 +++++++++++++++++++
 tb/tb_aes_stream_loader.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_loader.sv
// ---------------------------------------------------------------------------
// aes_stream_loader
//
// Byte-serial front-end for an AES core. Collects a K-bit key followed by a
// 128-bit message from an 8-bit input stream, pulses the core's load/enable,
// waits for the core to finish, then streams the 128-bit result out as 16
// bytes. A watchdog returns to IDLE with a sticky error flag if the core
// never reports done.
//
// Handshakes (both streams): a byte moves on a rising clk edge when the
// producer's valid and the consumer's ready are both high in that cycle.
// The producer holds data stable while valid is high and ready is low;
// valid never depends combinationally on ready.
//
// Parameters:
//   K        key length in bits: 128, 192 or 256
//   CE_HOLD  cycles core_ce stays high once key and message are complete (>= 1)
//   TIMEOUT  cycles allowed from core_ce falling to core_done (>= 1)
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   in_valid/in_data/in_ready     input byte stream (key bytes, then message)
//   core_ce                 load/enable to the core
//   core_key, core_msg      assembled operands, stable from START through RUN
//   core_done, core_result  core completion flag and result
//   out_valid/out_data/out_ready  result byte stream, MSB-first
//   busy                    high in every state except IDLE
//   timeout_err             sticky watchdog flag, cleared by the next input byte
//   dbg_state               current FSM state encoding
// ---------------------------------------------------------------------------
module aes_stream_loader #(
    parameter int K       = 128,
    parameter int CE_HOLD = 2,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    input  logic [7:0]     in_data,
    output logic           in_ready,
    output logic           core_ce,
    output logic [K-1:0]   core_key,
    output logic [127:0]   core_msg,
    input  logic           core_done,
    input  logic [127:0]   core_result,
    output logic           out_valid,
    output logic [7:0]     out_data,
    input  logic           out_ready,
    output logic           busy,
    output logic           timeout_err,
    output logic [2:0]     dbg_state
);

    localparam int NKB     = K / 8;
    localparam int NTOT    = NKB + 16;
    localparam int CNT_MAX = (NTOT > CE_HOLD) ? NTOT : CE_HOLD;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int TW      = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;      // byte index in LOAD, hold cycles in START, bytes sent in DRAIN
    logic [TW-1:0]   r_tcnt;     // watchdog cycles spent in RUN
    logic [K-1:0]    r_key;
    logic [127:0]    r_msg;
    logic [127:0]    r_res;      // output shift register, top byte is on out_data
    logic            r_in_ready;
    logic            r_core_ce;
    logic            r_out_valid;
    logic            r_busy;
    logic            r_timeout_err;

    logic            w_in_xfer;
    logic            w_out_xfer;

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_tcnt        <= '0;
            r_key         <= '0;
            r_msg         <= '0;
            r_res         <= '0;
            r_in_ready    <= 1'b0;
            r_core_ce     <= 1'b0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_in_xfer) begin
                        // Key bytes shift in at the bottom; after NKB bytes
                        // the first byte sits in core_key[K-1:K-8].
                        r_key         <= {r_key[K-9:0], in_data};
                        r_cnt         <= CW'(1);
                        r_timeout_err <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (w_in_xfer) begin
                        if (r_cnt < CW'(NKB)) begin
                            r_key <= {r_key[K-9:0], in_data};
                        end else begin
                            r_msg <= {r_msg[119:0], in_data};
                        end
                        if (r_cnt == CW'(NTOT - 1)) begin
                            // Drop in_ready on the same edge so no extra byte
                            // slips in while the core is loading.
                            r_cnt      <= '0;
                            r_in_ready <= 1'b0;
                            r_core_ce  <= 1'b1;
                            r_state    <= S_START;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                S_START: begin
                    // core_done is deliberately not looked at here: the core
                    // may still show a stale done while it is being loaded.
                    if (r_cnt == CW'(CE_HOLD - 1)) begin
                        r_core_ce <= 1'b0;
                        r_cnt     <= '0;
                        r_tcnt    <= '0;
                        r_state   <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_RUN: begin
                    // done is tested before the watchdog so it wins a tie.
                    if (core_done) begin
                        r_res       <= core_result;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_DRAIN;
                    end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_in_ready    <= 1'b1;
                        r_tcnt        <= '0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end

                S_DRAIN: begin
                    // Shift only on a transfer, so out_data holds while stalled.
                    if (w_out_xfer) begin
                        r_res <= {r_res[119:0], 8'h00};
                        if (r_cnt == CW'(15)) begin
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign core_ce     = r_core_ce;
    assign core_key    = r_key;
    assign core_msg    = r_msg;
    assign out_valid   = r_out_valid;
    assign out_data    = r_res[127:120];
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_aes_stream_loader.sv
// ---------------------------------------------------------------------------
// Bench for aes_stream_loader. Two instances share clock, reset, in_data and
// out_ready: "a" with K=128 and "b" with K=256; sel picks which one is
// driven and watched. Each instance has a small core stub:
// result = msg ^ key[K-1:K-128], done pulsed 11 cycles after core_ce falls.
// ---------------------------------------------------------------------------
module tb_aes_stream_loader;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         out_ready = 1'b1;
    logic         sel = 1'b0;
    logic         never_done = 1'b0;
    logic         stale = 1'b0;
    logic         bp = 1'b0;
    int           bp_idx = 0;

    always #5 clk = ~clk;

    // ---------------- instance a: K=128 ----------------
    logic         a_in_ready, a_ce, a_done, a_ov, a_busy, a_terr;
    logic [127:0] a_key, a_msg, a_result;
    logic [7:0]   a_od;
    logic [2:0]   a_state;

    aes_stream_loader #(.K(128), .CE_HOLD(2), .TIMEOUT(64)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(in_valid && !sel), .in_data(in_data), .in_ready(a_in_ready),
        .core_ce(a_ce), .core_key(a_key), .core_msg(a_msg),
        .core_done(a_done), .core_result(a_result),
        .out_valid(a_ov), .out_data(a_od), .out_ready(out_ready),
        .busy(a_busy), .timeout_err(a_terr), .dbg_state(a_state)
    );

    logic [3:0] sa_cnt;
    logic       sa_armed, sa_done;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sa_cnt <= 4'd0; sa_armed <= 1'b0; sa_done <= 1'b0;
        end else if (a_ce) begin
            sa_armed <= 1'b1; sa_cnt <= 4'd0; sa_done <= 1'b0;
        end else if (sa_armed && sa_cnt == 4'd10) begin
            sa_armed <= 1'b0; sa_done <= !never_done;
        end else begin
            if (sa_armed) sa_cnt <= sa_cnt + 4'd1;
            sa_done <= 1'b0;
        end
    end
    // While loading, the stub shows a stale done with a wrong result.
    assign a_done   = sa_done | (stale & a_ce);
    assign a_result = a_ce ? ~(a_msg ^ a_key) : (a_msg ^ a_key);

    // ---------------- instance b: K=256 ----------------
    logic         b_in_ready, b_ce, b_done, b_ov, b_busy, b_terr;
    logic [255:0] b_key;
    logic [127:0] b_msg, b_result;
    logic [7:0]   b_od;
    logic [2:0]   b_state;

    aes_stream_loader #(.K(256), .CE_HOLD(2), .TIMEOUT(64)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(in_valid && sel), .in_data(in_data), .in_ready(b_in_ready),
        .core_ce(b_ce), .core_key(b_key), .core_msg(b_msg),
        .core_done(b_done), .core_result(b_result),
        .out_valid(b_ov), .out_data(b_od), .out_ready(out_ready),
        .busy(b_busy), .timeout_err(b_terr), .dbg_state(b_state)
    );

    logic [3:0] sb_cnt;
    logic       sb_armed, sb_done;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_cnt <= 4'd0; sb_armed <= 1'b0; sb_done <= 1'b0;
        end else if (b_ce) begin
            sb_armed <= 1'b1; sb_cnt <= 4'd0; sb_done <= 1'b0;
        end else if (sb_armed && sb_cnt == 4'd10) begin
            sb_armed <= 1'b0; sb_done <= !never_done;
        end else begin
            if (sb_armed) sb_cnt <= sb_cnt + 4'd1;
            sb_done <= 1'b0;
        end
    end
    assign b_done   = sb_done | (stale & b_ce);
    assign b_result = b_ce ? ~(b_msg ^ b_key[255:128]) : (b_msg ^ b_key[255:128]);

    // ---------------- selected-instance view ----------------
    logic       m_in_ready, m_ce, m_ov, m_busy, m_terr;
    logic [7:0] m_od;
    logic [2:0] m_state;
    assign m_in_ready = sel ? b_in_ready : a_in_ready;
    assign m_ce       = sel ? b_ce       : a_ce;
    assign m_ov       = sel ? b_ov       : a_ov;
    assign m_od       = sel ? b_od       : a_od;
    assign m_busy     = sel ? b_busy     : a_busy;
    assign m_terr     = sel ? b_terr     : a_terr;
    assign m_state    = sel ? b_state    : a_state;

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         xfer = 0;
    int         ce_cnt = 0;
    int         irdy_bad = 0;
    int         ov_seen = 0;
    logic       held = 1'b0;
    logic [7:0] held_data = 8'h00;
    logic [7:0] mon_exp;

    localparam logic [127:0] E1 = 128'h00102030405060708090A0B0C0D0E0F0;
    localparam logic [127:0] E2 = 128'hAAABA8A9AEAFACADA2A3A0A1A6A7A4A5;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Out_ready pattern 1,0,0 repeating when backpressure is on.
    always @(posedge clk) begin
        #1;
        if (bp) begin
            out_ready = (bp_idx % 3 == 0);
            bp_idx++;
        end else begin
            out_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_ce) ce_cnt++;
    end

    // Monitor: outputs are stable at the falling edge; a transfer sampled
    // here completes on the following rising edge.
    always @(negedge clk) begin
        if (reset) begin
            held = 1'b0;
        end else begin
            if (held && m_ov) check("stall_hold", m_od, held_data);
            if (m_ov && m_in_ready) irdy_bad++;
            if (m_ov) ov_seen++;
            if (m_ov && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_out: got byte %0h, expected none", m_od);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("out_byte", m_od, mon_exp);
                end
                xfer++;
                held = 1'b0;
            end else if (m_ov) begin
                held = 1'b1;
                held_data = m_od;
            end else begin
                held = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!m_in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!m_in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL in_accept: in_ready stuck at 0, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Key byte i = i; message byte j = msg_base + j*msg_step.
    task automatic load_op(input int nkb, input logic [7:0] msg_base,
                           input logic [7:0] msg_step, input logic [127:0] exp_res,
                           input bit push);
        logic [7:0] b;
        if (push) begin
            for (int i = 0; i < 16; i++) exp_q.push_back(exp_res[127-8*i -: 8]);
        end
        for (int i = 0; i < nkb + 16; i++) begin
            if (i < nkb) b = 8'(i);
            else b = msg_base + 8'(i - nkb) * msg_step;
            if (i == nkb + 15) check("ce_before_last", m_ce, 0);
            send_byte(b);
        end
        check("ce_after_last", m_ce, 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || m_busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_wait: busy=%0b with %0d bytes pending, expected idle", m_busy, exp_q.size());
        end
        check("busy_end", m_busy, 0);
        check("state_end", m_state, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctrl_a"}, {a_in_ready, a_ce, a_ov, a_busy, a_terr}, 0);
        check({tag, "_state_a"}, a_state, 0);
        check({tag, "_out_data_a"}, a_od, 0);
        check({tag, "_key_a"}, a_key, 0);
        check({tag, "_msg_a"}, a_msg, 0);
        check({tag, "_ctrl_b"}, {b_in_ready, b_ce, b_ov, b_busy, b_terr, b_state}, 0);
        check({tag, "_key_b"}, b_key, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int t;
        int cyc;

        // Reset values while reset is held, then IDLE with in_ready up.
        #2;
        check_reset_vals("reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", a_in_ready, 1);
        check("idle_busy", a_busy, 0);

        // 1: K=128 basic operation.
        sel = 1'b0;
        ce_cnt = 0;
        load_op(16, 8'h00, 8'h11, E1, 1);
        check("t1_key", a_key, 128'h000102030405060708090A0B0C0D0E0F);
        check("t1_msg", a_msg, 128'h00112233445566778899AABBCCDDEEFF);
        wait_idle();
        check("t1_ce_cycles", ce_cnt, 2);

        // 2: K=256, message all 0xAA.
        sel = 1'b1;
        ce_cnt = 0;
        load_op(32, 8'hAA, 8'h00, E2, 1);
        check("t2_key_top", b_key[255:248], 8'h00);
        check("t2_key_bottom", b_key[7:0], 8'h1F);
        wait_idle();
        check("t2_ce_cycles", ce_cnt, 2);

        // 3: backpressure on the result stream.
        sel = 1'b0;
        xfer = 0;
        irdy_bad = 0;
        bp_idx = 0;
        bp = 1'b1;
        load_op(16, 8'h00, 8'h11, E1, 1);
        wait_idle();
        bp = 1'b0;
        repeat (5) @(negedge clk);
        check("t3_transfers", xfer, 16);
        check("t3_in_ready_in_drain", irdy_bad, 0);

        // 4: watchdog when the core never finishes.
        never_done = 1'b1;
        ov_seen = 0;
        load_op(16, 8'h00, 8'h11, E1, 0);
        t = 0;
        while (a_ce && t < 100) begin
            @(negedge clk);
            t++;
        end
        cyc = 0;
        while (!a_terr && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("t4_timeout_cycles", cyc, 64);
        check("t4_state_idle", a_state, 0);
        check("t4_busy", a_busy, 0);
        repeat (3) @(negedge clk);
        check("t4_err_sticky", a_terr, 1);
        check("t4_no_output", ov_seen, 0);
        never_done = 1'b0;
        send_byte(8'h00);
        check("t4_err_cleared", a_terr, 0);

        // 5a: async reset in LOAD after 10 bytes.
        for (int i = 1; i < 10; i++) send_byte(8'(i));
        check("t5_in_load", a_state, 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("t5_load_rst");
        @(negedge clk);
        reset = 1'b0;

        // 5b: async reset in DRAIN after 5 bytes, then a clean operation.
        xfer = 0;
        load_op(16, 8'h00, 8'h11, E1, 1);
        t = 0;
        while (xfer < 5 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("t5_drain_started", xfer >= 5, 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_reset_vals("t5_drain_rst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        load_op(16, 8'h00, 8'h11, E1, 1);
        wait_idle();

        // 6: stale done while loading must not be captured.
        stale = 1'b1;
        load_op(16, 8'h00, 8'h11, E1, 1);
        wait_idle();
        stale = 1'b0;

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
